// File: rtl/sseg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : sseg_scan
//  Purpose  : Time-multiplexed scan controller for a bank of seven-segment
//             digits sharing one sseg decoder. Holds a double-buffered
//             3-bit value per digit, steps a one-hot digit enable with a
//             blanking gap at the start of every slot, and applies host
//             updates only at frame boundaries.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             en                - scan enable (0 = blank, hold at digit 0)
//             wr_en/wr_addr/wr_data - shadow bank write port
//             commit            - request shadow->active copy at next frame
//             commit_pend       - commit requested, not yet applied
//             frame             - pulse in the last cycle of each frame
//             bin               - value of the current digit (to sseg.bin)
//             dig               - one-hot digit enable, zero while blanked
//             blank             - high when dig is all zero
//  Revision : 1.0 - initial release
// ============================================================================
module sseg_scan #(
    parameter int AW    = 2,
    parameter int DIV   = 1024,
    parameter int BLANK = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [2:0]           wr_data,
    input  logic                 commit,
    output logic                 commit_pend,
    output logic                 frame,
    output logic [2:0]           bin,
    output logic [(2**AW)-1:0]   dig,
    output logic                 blank
);

    localparam int              c_ndig     = 2**AW;
    localparam int              c_cw       = $clog2(DIV);
    localparam logic [c_cw-1:0] c_cnt_last = c_cw'(DIV - 1);
    localparam logic [c_cw-1:0] c_blank    = c_cw'(BLANK);
    localparam logic [AW-1:0]   c_idx_last = AW'(c_ndig - 1);

    logic [c_cw-1:0] r_cnt;
    logic [AW-1:0]   r_idx;
    logic [2:0]      r_shadow [c_ndig];
    logic [2:0]      r_active [c_ndig];
    logic            r_pend;

    logic w_last_cnt;
    logic w_boundary;
    logic w_copy;

    assign w_last_cnt = (r_cnt == c_cnt_last);
    assign w_boundary = w_last_cnt && (r_idx == c_idx_last);

    // While scanning, the copy waits for the frame boundary so a frame is
    // never mixed; while disabled nothing is shown, so it applies at once.
    assign w_copy = r_pend && (!en || w_boundary);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_pend <= 1'b0;
            for (int i = 0; i < c_ndig; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            if (!en) begin
                r_cnt <= '0;
                r_idx <= '0;
            end else if (w_last_cnt) begin
                r_cnt <= '0;
                r_idx <= r_idx + AW'(1);   // wraps naturally, NDIG = 2**AW
            end else begin
                r_cnt <= r_cnt + c_cw'(1);
            end

            // The copy reads shadow before this cycle's write lands, so a
            // write in the copy cycle waits for the next commit.
            for (int i = 0; i < c_ndig; i++) begin
                if (w_copy) begin
                    r_active[i] <= r_shadow[i];
                end
            end

            if (wr_en) begin
                r_shadow[wr_addr] <= wr_data;
            end

            // A commit in the copy cycle re-arms the request.
            r_pend <= commit | (r_pend & ~w_copy);
        end
    end

    // Outputs decode from registers only. IDLE holds cnt at 0, which is
    // inside the gap, so IDLE and GAP share the same blanked decode.
    always_comb begin
        dig = '0;
        if (r_cnt >= c_blank) begin
            dig[r_idx] = 1'b1;
        end
    end

    assign blank       = (r_cnt < c_blank);
    assign bin         = r_active[r_idx];
    assign frame       = w_boundary;
    assign commit_pend = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sseg_scan
//  Purpose  : Self-checking bench for sseg_scan (AW=2, DIV=8, BLANK=2).
//             A driver issues directed and random stimulus and pushes the
//             reference model's expected outputs into a queue; a monitor
//             pops and compares on every falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sseg_scan;

    localparam int AW    = 2;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int NDIG  = 4;

    logic          clk = 1'b0;
    logic          rst, en, wr_en, commit;
    logic [AW-1:0] wr_addr;
    logic [2:0]    wr_data;
    logic          commit_pend, frame, blank;
    logic [2:0]    bin;
    logic [3:0]    dig;

    always #5 clk = ~clk;

    sseg_scan #(.AW(AW), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .commit      (commit),
        .commit_pend (commit_pend),
        .frame       (frame),
        .bin         (bin),
        .dig         (dig),
        .blank       (blank)
    );

    typedef struct packed {
        logic [3:0] dig;
        logic       blank;
        logic [2:0] bin;
        logic       frame;
        logic       pend;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: time since the scan started, plus the two banks.
    int m_t;
    int m_shadow [NDIG];
    int m_active [NDIG];
    bit m_pend;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t r;
        int   pos;
        int   d;
        bit   on;
        pos     = m_t % DIV;
        d       = (m_t / DIV) % NDIG;
        on      = (pos >= BLANK);
        r.dig   = on ? 4'(1 << d) : 4'd0;
        r.blank = !on;
        r.bin   = 3'(m_active[d]);
        r.frame = (pos == DIV - 1) && (d == NDIG - 1);
        r.pend  = m_pend;
        return r;
    endfunction

    task automatic model_step(input bit r, input bit e, input bit w,
                              input int a, input int dt, input bit c);
        bit boundary;
        bit copy;
        if (r) begin
            m_t    = 0;
            m_pend = 1'b0;
            for (int i = 0; i < NDIG; i++) begin
                m_shadow[i] = 0;
                m_active[i] = 0;
            end
        end else begin
            boundary = ((m_t % DIV) == DIV - 1) && (((m_t / DIV) % NDIG) == NDIG - 1);
            copy     = m_pend && (!e || boundary);
            if (copy) m_active = m_shadow;
            if (w) m_shadow[a] = dt;
            m_pend = c || (m_pend && !copy);
            m_t    = e ? (m_t + 1) % (NDIG * DIV) : 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        q.push_back(model_out());
    endtask

    task automatic drive(input bit r, input bit e, input bit w,
                         input int a, input int dt, input bit c);
        rst     = r;
        en      = e;
        wr_en   = w;
        wr_addr = a[AW-1:0];
        wr_data = dt[2:0];
        commit  = c;
        model_step(r, e, w, a, dt, c);
    endtask

    task automatic do_reset();
        tick(); drive(1, 0, 0, 0, 0, 0);
        tick(); drive(1, 0, 0, 0, 0, 0);
        tick(); drive(0, 0, 0, 0, 0, 0);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("mon_dig",   int'(dig),         int'(e.dig));
                check("mon_blank", int'(blank),       int'(e.blank));
                check("mon_bin",   int'(bin),         int'(e.bin));
                check("mon_frame", int'(frame),       int'(e.frame));
                check("mon_pend",  int'(commit_pend), int'(e.pend));
            end
        end
    end

    // Driver
    initial begin
        int tbl [4];
        bit e_r;
        tbl = '{3, 5, 7, 1};

        // Reset and idle
        drive(1, 0, 0, 0, 0, 0);
        tick(); drive(1, 0, 0, 0, 0, 0);
        tick();
        check("t1_rst_dig",   int'(dig), 0);
        check("t1_rst_blank", int'(blank), 1);
        check("t1_rst_bin",   int'(bin), 0);
        check("t1_rst_frame", int'(frame), 0);
        check("t1_rst_pend",  int'(commit_pend), 0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check("t1_idle_dig",   int'(dig), 0);
        check("t1_idle_blank", int'(blank), 1);
        check("t1_idle_bin",   int'(bin), 0);
        drive(0, 0, 0, 0, 0, 0);

        // Free scan plus buffered update
        for (int c = 0; c < 72; c++) begin
            bit w;
            tick();
            if (c < 32)
                check("t2_dig", int'(dig), ((c % 8) < 2) ? 0 : (1 << ((c / 8) % 4)));
            check("t2_frame", int'(frame), int'(c == 31 || c == 63));
            if (c >= 9 && c <= 31) check("t3_pend_hi", int'(commit_pend), 1);
            if (c >= 32)           check("t3_pend_lo", int'(commit_pend), 0);
            if (c <= 31)           check("t3_bin_old", int'(bin), 0);
            if (c >= 32 && c < 64) check("t3_bin_new", int'(bin), tbl[(c - 32) / 8]);
            w = (c >= 4 && c <= 7);
            drive(0, 1, w, w ? c - 4 : 0, w ? tbl[c - 4] : 0, c == 8);
        end

        // Commit on a boundary with nothing pending
        do_reset();
        for (int c = 0; c < 73; c++) begin
            tick();
            if (c >= 32 && c <= 39) check("t4_bin_hold", int'(bin), 0);
            if (c >= 32 && c <= 63) check("t4_pend", int'(commit_pend), 1);
            if (c >= 64 && c <= 71) check("t4_bin_new", int'(bin), 6);
            if (c == 64)            check("t4_pend_clr", int'(commit_pend), 0);
            drive(0, 1, c == 31, 0, 6, c == 31);
        end

        // Disable mid-slot, then re-enable
        do_reset();
        for (int c = 0; c < 40; c++) begin
            tick();
            if (c == 20) check("t5_dig_on", int'(dig), 4);
            if (c >= 21 && c <= 26) begin
                check("t5_dig_off", int'(dig), 0);
                check("t5_blank",   int'(blank), 1);
            end
            if (c == 27) begin
                check("t5_dig_back", int'(dig), 1);
                check("t5_blank_lo", int'(blank), 0);
            end
            drive(0, !(c >= 20 && c < 25), 0, 0, 0, 0);
        end

        // Reset while a commit is pending and the active bank is loaded
        do_reset();
        for (int c = 0; c < 96; c++) begin
            bit w;
            int a;
            int d;
            tick();
            if (c == 39) begin
                check("t6_pre_pend", int'(commit_pend), 1);
                check("t6_pre_bin",  int'(bin), 1);
            end
            if (c == 41) begin
                check("t6_dig", int'(dig), 0);
                check("t6_bin", int'(bin), 0);
            end
            if (c >= 41)            check("t6_pend", int'(commit_pend), 0);
            if (c >= 81 && c <= 88) check("t6_nocopy", int'(bin), 0);
            w = (c < 4) || (c == 45);
            a = (c == 45) ? 1 : c;
            d = (c == 45) ? 5 : c + 1;
            drive(c == 40, 1, w, w ? a : 0, w ? d : 0, c == 4 || c == 35);
        end

        // Random traffic against the model
        do_reset();
        e_r = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if ($urandom_range(0, 59) == 0) e_r = !e_r;
            drive($urandom_range(0, 1499) == 0, e_r,
                  $urandom_range(0, 3) == 0,
                  int'($urandom_range(0, NDIG - 1)),
                  int'($urandom_range(0, 7)),
                  $urandom_range(0, 39) == 0);
        end

        tick();
        @(negedge clk);
        #1;
        check("drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sseg_scan.md
# sseg_scan

Time-multiplexed scan controller for a bank of seven-segment digits that share one `sseg` decoder. It holds one 3-bit value per digit in a double-buffered register file and drives the shared decoder's `bin` input. It also steps a one-hot digit enable through the digits and inserts a blanking gap between digits to suppress ghosting. Host writes go to a shadow bank and become visible only at a frame boundary, so a displayed frame never mixes old and new values.

## Interface
- `AW`, 2: digit address width; digit count NDIG = 2**AW (AW 1..3).
- `DIV`, 1024: clocks per digit slot; requires DIV > BLANK.
- `BLANK`, 16: blanked clocks at the start of each slot; must be ≥ 1.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  scan enable; 0 blanks the display and holds the scan at digit 0.
- `wr_en`  in  1  write strobe for the shadow bank.
- `wr_addr`  in  AW  shadow digit index.
- `wr_data`  in  3  value for the shadow digit; the `sseg` code 0..7.
- `commit`  in  1  single-cycle request to copy shadow to active at the next frame boundary.
- `commit_pend`  out  1  a commit is requested but not yet applied.
- `frame`  out  1  single-cycle pulse in the last cycle of each scanned frame.
- `bin`  out  3  value of the current digit; connects to the `sseg` decoder `bin` input.
- `dig`  out  NDIG  one-hot digit enable, active-high; all zero while blanked.
- `blank`  out  1  high when `dig` is all zero.

## Operation
- Registers:
  - slot counter `cnt` (0..DIV-1).
  - digit index `idx` (0..NDIG-1).
  - shadow bank and active bank, NDIG x 3 bits each.
  - pending flag.
- The state is derived from the registers: IDLE (en=0), GAP (en=1, cnt<BLANK), ON (en=1, cnt≥BLANK).
- IDLE: cnt=0, idx=0, dig=0, blank=1, frame=0.
- Scan sequence:
  - With en=1, cnt increments every cycle.
  - At cnt=DIV-1, cnt wraps to 0 and idx increments.
  - idx wraps from NDIG-1 to 0. That wrap cycle (cnt=DIV-1, idx=NDIG-1) is the frame boundary and frame=1.
- Outputs:
  - ON: dig = 1<<idx, blank=0.
  - GAP and IDLE: dig=0, blank=1.
  - bin = active[idx] in every state; in IDLE it shows active[0].
- All outputs decode from registers only. There is no combinational path from any input to any output.
- Shadow writes:
  - When wr_en=1, shadow[wr_addr] <= wr_data.
  - Writes are accepted in every state. They never affect `bin` directly.
- Commit:
  - commit=1 sets pend, which is visible on commit_pend the next cycle.
  - commit while pend=1 has no additional effect.
- Copy:
  - en=1: in a frame-boundary cycle with registered pend=1, active <= shadow (all digits) and pend <= 0.
  - en=0: a cycle with registered pend=1 copies and clears pend. The copy is not deferred.
- Same-cycle events:
  - The copy samples shadow as registered before that cycle's write, so a write in the copy cycle lands only in shadow and waits for the next commit.
  - commit asserted in the copy cycle re-sets pend, so the next boundary copies again.
  - commit asserted in a boundary cycle with pend=0 sets pend only. That copy happens at the following boundary.
- en transitions:
  - en 1→0 mid-slot: the next cycle is IDLE, cnt and idx clear, and pend and both banks are retained.
  - en 0→1: the scan starts in GAP of digit 0 with cnt=0.
- Reset: everything clears, including any operation in progress. dig=0, blank=1, bin=0, frame=0, commit_pend=0, and cnt, idx, both banks and pend are all zero.

## Timing
- Slot length is DIV cycles: BLANK cycles of GAP, then DIV-BLANK cycles of ON.
- Frame period is NDIG*DIV cycles. frame pulses once per period, in the cycle before idx returns to 0.
- Latencies:
  - wr_en is reflected in shadow the next cycle.
  - commit_pend rises 1 cycle after commit.
  - A copy becomes visible on `bin` in the first cycle of the new frame, which is the GAP of digit 0, so new data is never shown mid-frame.
- First cycle after rst release with en=1: cnt=0, GAP, dig=0.

## Test plan
Parameters for all scenarios: AW=2, DIV=8, BLANK=2.

1. Reset: drive rst=1 for 2 cycles, then rst=0 with en=0 → dig=0000, blank=1, bin=0, frame=0, commit_pend=0.
2. Free scan: en=1 from cycle 0 →
   - cycles 0-1: dig=0000.
   - cycles 2-7: dig=0001.
   - cycles 8-9: dig=0000.
   - cycles 10-15: dig=0010.
   - The pattern continues through digit 3. frame=1 at cycles 31, 63, ….
3. Buffered update:
   - Stimulus: write shadow addrs 0..3 = 3,5,7,1 at cycles 4-7, then commit at cycle 8.
   - commit_pend=1 from cycle 9 through cycle 31.
   - bin shows 0 for all digits until cycle 31; from cycle 32, bin=3,5,7,1 in slots 0..3.
   - commit_pend=0 from cycle 32.
4. Boundary commit:
   - Stimulus: pend=0; write addr0=6 and assert commit at cycle 31 (boundary).
   - No copy at 31; bin for digit 0 in cycles 32-39 is unchanged.
   - Copy at cycle 63; digit 0 shows 6 from cycle 64.
5. Disable mid-slot: drop en at cycle 20 (digit 2 ON) → dig=0000 from cycle 21. Re-assert en at cycle 25 → GAP at cycles 25-26, dig=0001 at cycle 27.
6. Reset mid-operation: pend=1, active bank holding nonzero values, rst at cycle 40 → from cycle 41, dig=0000, bin=0, commit_pend=0. After release, no copy occurs at the next boundary.
